// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader FSM state encoding and the width of the word-count
// field that opens every load session.
package instr_mem_loader_pkg;

    // Width of the little-endian word count sent at the head of a session.
    localparam int LDR_LEN_W = 16;

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_LEN_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERR    = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the instruction-memory loader.
// Each loaded byte lands in the next byte lane of the word, lowest lane first.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - restart assembly at byte lane 0 (word contents are kept)
//   load       - store byte_in into the current lane and advance the lane
//   byte_in    - incoming stream byte
//   word       - assembled 32-bit word (registered)
//   full       - three lanes are filled; the next load completes the word
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] byte_idx;

    // The lane index wraps naturally after the fourth byte, so consecutive
    // words need no explicit clear between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= 32'h0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (load) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx                      <= byte_idx + 2'd1;
        end
    end

    assign full = (byte_idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a byte stream over valid/ready,
// assembles little-endian 32-bit words and writes them sequentially into
// the instruction memory while holding the CPU in reset.
// A session is a 16-bit little-endian word count N followed by N*4 bytes.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start               - pulse that opens a load session (ignored while busy)
//   in_data, in_valid   - stream byte and its valid flag
//   in_ready            - a byte is accepted when in_valid && in_ready
//   mem_we, mem_addr,
//   mem_wdata           - instruction-memory write port
//   cpu_rst             - active-high CPU reset, released after a good load
//   busy                - session in progress
//   done, err           - level status of the last session
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra bit so a full-depth load can count to DEPTH without wrapping.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [LDR_LEN_W:0] DEPTH_CMP = (LDR_LEN_W + 1)'(DEPTH);

    ldr_state_t           state, state_d;
    logic [LDR_LEN_W-1:0] len, len_d, len_full;
    logic [IDX_W-1:0]     word_idx, word_idx_d, idx_inc;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic                 cpu_rst_d, done_d, err_d;
    logic                 accept, pk_clear, pk_load, pk_full;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len[7:0]};
    assign idx_inc  = word_idx + IDX_W'(1);

    instr_mem_loader_byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pk_clear),
        .load    (pk_load),
        .byte_in (in_data),
        .word    (mem_wdata),
        .full    (pk_full)
    );

    // State, session registers and outputs. Handshake and status outputs
    // are decoded from the next state so they are registered and line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LDR_IDLE;
            len      <= '0;
            word_idx <= '0;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            len      <= len_d;
            word_idx <= word_idx_d;
            mem_addr <= mem_addr_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            err      <= err_d;
            in_ready <= (state_d == LDR_LEN_LO) || (state_d == LDR_LEN_HI) ||
                        (state_d == LDR_DATA);
            busy     <= (state_d == LDR_LEN_LO) || (state_d == LDR_LEN_HI) ||
                        (state_d == LDR_DATA)   || (state_d == LDR_WRITE);
            mem_we   <= (state_d == LDR_WRITE);
        end
    end

    // Next-state logic. A new session may only be opened from an idle,
    // done or error state, which is what makes start ignored while busy.
    always_comb begin
        state_d    = state;
        len_d      = len;
        word_idx_d = word_idx;
        mem_addr_d = mem_addr;
        cpu_rst_d  = cpu_rst;
        done_d     = done;
        err_d      = err;
        pk_clear   = 1'b0;
        pk_load    = 1'b0;

        case (state)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (start) begin
                    state_d    = LDR_LEN_LO;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                end
            end
            LDR_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = LDR_LEN_HI;
                end
            end
            LDR_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d   = LDR_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else if ({1'b0, len_full} > DEPTH_CMP) begin
                        state_d = LDR_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = LDR_DATA;
                        pk_clear = 1'b1;
                    end
                end
            end
            LDR_DATA: begin
                if (accept) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        state_d    = LDR_WRITE;
                        mem_addr_d = word_idx[ADDR_W-1:0];
                    end
                end
            end
            LDR_WRITE: begin
                word_idx_d = idx_inc;
                if (LDR_LEN_W'(idx_inc) == len) begin
                    state_d   = LDR_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                end else begin
                    state_d = LDR_DATA;
                end
            end
            default: state_d = LDR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. Expected memory writes are
// queued as the words are streamed in and popped by a monitor whenever
// the loader drives mem_we.
module tb_instr_mem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    int vectors    = 0;
    int miscompares = 0;

    logic [37:0] sb_q[$];

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_we", 64'({mem_addr, mem_wdata}), 64'(0));
            end else begin
                check_output("mem_write", 64'({mem_addr, mem_wdata}), 64'(sb_q.pop_front()));
            end
        end
    end

    // Offer one byte and hold it until the loader accepts it.
    task automatic send_byte(input logic [7:0] b);
        int wait_cycles = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (in_ready !== 1'b1) begin
            check_output("ready_timeout", 64'(in_ready), 64'(1));
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Queue the expected write, then stream the word LSB first. An optional
    // gap with in_valid low follows byte gap_after; poke pulses start in it.
    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w,
                             input int gap_after, input bit poke);
        sb_q.push_back({addr, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (k == gap_after) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    check_output("gap_ready", 64'({in_ready, busy, done}), 64'(3'b110));
                    start = poke && (g == 0);
                end
                start = 1'b0;
            end
        end
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after the last data byte is accepted: one write cycle,
    // then the CPU is released on the following cycle.
    task automatic check_finish(input logic [ADDR_W-1:0] last_addr);
        @(negedge clk);
        check_output("final_we", 64'({mem_we, mem_addr, cpu_rst}), 64'({1'b1, last_addr, 1'b1}));
        @(negedge clk);
        check_output("finish_flags", 64'({mem_we, cpu_rst, busy, done, err, in_ready}),
                     64'(6'b000100));
    endtask

    task automatic check_reset_values(input string tag);
        check_output(tag, 64'({in_ready, mem_we, cpu_rst, busy, done, err, mem_addr, mem_wdata}),
                     64'({6'b001000, {ADDR_W{1'b0}}, 32'h0}));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1;
        @(negedge clk);

        // Start with a byte offered in the same cycle: not consumed in IDLE.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        @(negedge clk);
        start = 1'b0;
        check_output("start_enter", 64'({busy, in_ready, cpu_rst}), 64'(3'b111));
        @(posedge clk);
        #1 in_valid = 1'b0;
        send_byte(8'h00);
        send_word(6'd0, 32'h0062c033, -1, 1'b0);
        send_word(6'd1, 32'h0062c233, -1, 1'b0);
        check_finish(6'd1);

        // Restart after done: CPU re-enters reset on the next cycle.
        pulse_start();
        check_output("restart", 64'({cpu_rst, done, busy}), 64'(3'b101));
        send_header(16'd1);
        send_word(6'd0, 32'h00424233, -1, 1'b0);
        check_finish(6'd0);

        // Same two-word program with a three-cycle stall mid-word.
        pulse_start();
        send_header(16'd2);
        send_word(6'd0, 32'h0062c033, 1, 1'b0);
        send_word(6'd1, 32'h0062c233, -1, 1'b0);
        check_finish(6'd1);

        // Empty program: CPU released the cycle after the header.
        pulse_start();
        send_header(16'd0);
        @(negedge clk);
        check_output("empty_load", 64'({cpu_rst, done, busy, err}), 64'(4'b0100));

        // Oversized program is rejected and keeps the CPU in reset.
        pulse_start();
        send_header(16'd65);
        @(negedge clk);
        check_output("too_long", 64'({err, cpu_rst, done, busy, in_ready}), 64'(5'b11000));
        repeat (2) @(negedge clk);
        check_output("err_hold", 64'({err, cpu_rst}), 64'(2'b11));

        // Full-depth program with a start pulse in the middle of a word.
        pulse_start();
        check_output("err_cleared", 64'({err, busy}), 64'(2'b01));
        send_header(16'd64);
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            send_word(ADDR_W'(i), w, (i == 10) ? 1 : -1, i == 10);
        end
        check_finish(6'd63);

        // Reset dropped during the second word of a three-word load.
        pulse_start();
        send_header(16'd3);
        send_word(6'd0, 32'hdeadbeef, -1, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_values("post_reset_idle");

        check_output("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
